// File: rtl/game_flow_ctrl.sv
// Game sequencer: title/play/death/level/game-over/win flow.
// Optional: define INFINITE_LIVES_EN to disable life loss and GAME_OVER.
module game_flow_ctrl #(
   parameter int LIVES        = 3,
   parameter int DEATH_FRAMES = 60,
   parameter int LEVEL_FRAMES = 90,
   parameter int NUM_LEVELS   = 3
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       start,
   input  logic       is_dead,
   input  logic       exit_hit,
   output logic [2:0] state,
   output logic [1:0] level,
   output logic [2:0] lives,
   output logic       move_en,
   output logic       restart,
   output logic       reset1,
   output logic       reset2,
   output logic       reset3
);

   typedef enum logic [2:0] {
      S_TITLE      = 3'd0,
      S_PLAY       = 3'd1,
      S_DYING      = 3'd2,
      S_LEVEL_DONE = 3'd3,
      S_GAME_OVER  = 3'd4,
      S_WIN        = 3'd5
   } state_t;

   localparam logic [7:0] LP_DEATH_LAST = 8'(DEATH_FRAMES - 1);
   localparam logic [7:0] LP_LEVEL_LAST = 8'(LEVEL_FRAMES - 1);
   localparam logic [1:0] LP_LAST_LEVEL = 2'(NUM_LEVELS - 1);
   localparam logic [2:0] LP_LIVES      = 3'(LIVES);

   state_t     r_state, w_state_n;
   logic [1:0] r_level, w_level_n;
   logic [2:0] r_lives, w_lives_n;
   logic [7:0] r_timer, w_timer_n;
   logic [1:0] r_blank, w_blank_n;
   logic       r_frame_q, r_start_q;
   logic       r_restart, w_restart_n;
   logic       r_reset1, w_reset1_n;
   logic       r_reset2, w_reset2_n;
   logic       r_reset3, w_reset3_n;
   logic       w_tick, w_go;

   assign w_tick = frame_clk & ~r_frame_q;
   assign w_go   = start & ~r_start_q;

   // State, counters, edge detectors and registered pulses
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state   <= S_TITLE;
         r_level   <= 2'd0;
         r_lives   <= LP_LIVES;
         r_timer   <= 8'd0;
         r_blank   <= 2'd0;
         r_frame_q <= 1'b0;
         r_start_q <= 1'b0;
         r_restart <= 1'b0;
         r_reset1  <= 1'b0;
         r_reset2  <= 1'b0;
         r_reset3  <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_level   <= w_level_n;
         r_lives   <= w_lives_n;
         r_timer   <= w_timer_n;
         r_blank   <= w_blank_n;
         r_frame_q <= frame_clk;
         r_start_q <= start;
         r_restart <= w_restart_n;
         r_reset1  <= w_reset1_n;
         r_reset2  <= w_reset2_n;
         r_reset3  <= w_reset3_n;
      end
   end

   // Next-state, counter updates and pulse requests
   always_comb begin
      w_state_n   = r_state;
      w_level_n   = r_level;
      w_lives_n   = r_lives;
      w_timer_n   = r_timer;
      w_blank_n   = (r_blank != 2'd0) ? r_blank - 2'd1 : 2'd0;
      w_restart_n = 1'b0;
      w_reset1_n  = 1'b0;
      w_reset2_n  = 1'b0;
      w_reset3_n  = 1'b0;
      unique case (r_state)
         S_TITLE, S_GAME_OVER, S_WIN: begin
            if (w_go) begin
               w_level_n   = 2'd0;
               w_lives_n   = LP_LIVES;
               w_restart_n = 1'b1;
               w_reset1_n  = 1'b1;
               w_blank_n   = 2'd2;
               w_state_n   = S_PLAY;
            end
         end
         S_PLAY: begin
            if (r_blank == 2'd0) begin
               if (is_dead) begin
`ifndef INFINITE_LIVES_EN
                  w_lives_n = (r_lives != 3'd0) ? r_lives - 3'd1 : 3'd0;
`endif
                  w_timer_n = 8'd0;
                  w_state_n = S_DYING;
               end else if (exit_hit) begin
                  w_timer_n = 8'd0;
                  w_state_n = S_LEVEL_DONE;
               end
            end
         end
         S_DYING: begin
            if (w_tick) begin
               w_timer_n = r_timer + 8'd1;
               if (r_timer == LP_DEATH_LAST) begin
`ifdef INFINITE_LIVES_EN
                  w_restart_n = 1'b1;
                  w_blank_n   = 2'd2;
                  w_state_n   = S_PLAY;
`else
                  if (r_lives == 3'd0) begin
                     w_state_n = S_GAME_OVER;
                  end else begin
                     w_restart_n = 1'b1;
                     w_blank_n   = 2'd2;
                     w_state_n   = S_PLAY;
                  end
`endif
               end
            end
         end
         S_LEVEL_DONE: begin
            if (w_tick) begin
               w_timer_n = r_timer + 8'd1;
               if (r_timer == LP_LEVEL_LAST) begin
                  if (r_level == LP_LAST_LEVEL) begin
                     w_state_n = S_WIN;
                  end else begin
                     w_level_n   = r_level + 2'd1;
                     w_restart_n = 1'b1;
                     w_reset2_n  = (r_level == 2'd0);
                     w_reset3_n  = (r_level == 2'd1);
                     w_blank_n   = 2'd2;
                     w_state_n   = S_PLAY;
                  end
               end
            end
         end
         default: w_state_n = S_TITLE;
      endcase
   end

   assign state   = r_state;
   assign level   = r_level;
   assign lives   = r_lives;
   assign move_en = (r_state == S_PLAY);
   assign restart = r_restart;
   assign reset1  = r_reset1;
   assign reset2  = r_reset2;
   assign reset3  = r_reset3;

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Top-level game sequencer for the platformer character datapath. Owns the title, play, death, level-complete, game-over and win flow. Drives the character block's `restart` and per-level teleport pulses (`reset1`/`reset2`/`reset3`) and gates player movement. Tracks the current level and remaining lives, counting all delays in frames from `frame_clk`.

## Interface
Parameters:
- `LIVES`, 3: lives at game start; range 1–7.
- `DEATH_FRAMES`, 60: frames spent in DYING before respawn or game over; range 1–255.
- `LEVEL_FRAMES`, 90: frames spent in LEVEL_DONE before the next level or win; range 1–255.
- `NUM_LEVELS`, 3: number of levels; range 1–3.

Ports:
- `Clk` in 1: system clock (50 MHz).
- `Reset` in 1: synchronous, active-high.
- `frame_clk` in 1: frame clock (~60 Hz), asynchronous-rate level signal.
- `start` in 1: start key, level signal.
- `is_dead` in 1: character dead flag.
- `exit_hit` in 1: character overlaps the current level's exit tile; from map collision logic.
- `state` out 3: TITLE=0, PLAY=1, DYING=2, LEVEL_DONE=3, GAME_OVER=4, WIN=5.
- `level` out 2: current level index, 0-based.
- `lives` out 3: remaining lives.
- `move_en` out 1: high only in PLAY; gates the move and jump keys upstream.
- `restart` out 1: one-Clk pulse; clears the character's dead and jump state and returns it to its checkpoint.
- `reset1`, `reset2`, `reset3` out 1 each: one-Clk pulses; place the character at the start of level 0/1/2.

## Operation
- Frame tick: `frame_clk` is registered once. `tick = frame_clk & ~frame_clk_q` (one Clk wide).
- Start edge: `start` is registered once. `go = start & ~start_q`. Holding `start` never re-triggers.
- Game start, from TITLE, GAME_OVER or WIN on `go`:
  - `level` ← 0, `lives` ← LIVES.
  - Pulse `restart` and `reset1` in the same cycle.
  - Enter PLAY.
- PLAY:
  - Blanking: `is_dead` and `exit_hit` are ignored for the first 2 Clk cycles after entry, covering the character's one-cycle response to `restart`.
  - `is_dead`=1: `lives` ← `lives`−1, saturating at 0. Frame timer ← 0. Enter DYING.
  - Else `exit_hit`=1: frame timer ← 0. Enter LEVEL_DONE.
  - `is_dead` has priority over `exit_hit` when both are high in the same cycle.
- DYING:
  - Timer increments on each `tick`.
  - On the `tick` where the timer equals DEATH_FRAMES−1:
    - If `lives`==0, enter GAME_OVER.
    - Else pulse `restart` only (respawn at checkpoint) and enter PLAY.
- LEVEL_DONE:
  - Timer increments on each `tick`.
  - On the `tick` where the timer equals LEVEL_FRAMES−1:
    - If `level`==NUM_LEVELS−1, enter WIN.
    - Else `level` ← `level`+1, pulse `restart` plus the `reset` line for the new level (`reset2` for level 1, `reset3` for level 2), and enter PLAY.
- GAME_OVER and WIN: hold `level` and `lives`. Only `go` leaves these states.
- `go` is ignored in PLAY, DYING and LEVEL_DONE.
- Pulse outputs are registered, never combinational. No two `reset`N lines are ever high together.

## Timing
- Values after Reset: `state`=TITLE, `level`=0, `lives`=LIVES, `move_en`=0, `restart`=0, `reset1`–`reset3`=0, timer=0, edge registers=0.
- Reset mid-operation returns to TITLE on the next edge and cancels any pending pulse.
- Latency from a triggering input to a registered state change or pulse: 1 Clk.
- `move_en` updates in the same cycle as `state`.
- The PLAY→DYING transition is taken on the cycle `is_dead` is seen; it does not wait for a `tick`.
- Timer is 8 bits and is compared for equality only. A `tick` in the same cycle as the state entry is not counted.
- Delay timing:
  - DYING lasts exactly DEATH_FRAMES ticks, measured from the first tick after entry.
  - LEVEL_DONE lasts exactly LEVEL_FRAMES ticks, measured the same way.

## Configuration
- `INFINITE_LIVES_EN`:
  - Defined: `lives` never decrements and GAME_OVER is unreachable; DYING always ends with a `restart` pulse into PLAY.
  - Undefined: lives behave as described above.

## Test plan
- Reset, then a `start` pulse: `restart` and `reset1` are high for exactly 1 Clk, `state`=1, `lives`=3, `level`=0, `move_en`=1. Holding `start` for 100 cycles causes no further pulse.
- In PLAY, raise `is_dead`: `state`=2 next cycle, `lives`=2. After 60 ticks, a single `restart` pulse with no `reset`N, and `state`=1.
- Raise `is_dead` and `exit_hit` in the same cycle: DYING is taken, `level` is unchanged.
- `exit_hit` on level 0, then level 1: after 90 ticks each, pulses are `restart`+`reset2`, then `restart`+`reset3`. A third exit leads to WIN after 90 ticks, with no pulses.
- Three deaths from a fresh game: `lives` goes 2, 1, 0, then GAME_OVER after 60 ticks. With `INFINITE_LIVES_EN` defined, `lives` stays 3 and a respawn occurs each time.
- Assert Reset during DYING at tick 30: TITLE next cycle, all outputs at reset values, no `restart` pulse.
